// File: rtl/othello_draw_arbiter.sv
// rtl/othello_draw_arbiter.sv - Othello board draw arbiter (clear/disk/cursor) driving a cell plothelper
// Optional watchdog: define OTHELLO_DRAW_ARB_TIMEOUT_EN
module othello_draw_arbiter #(
    parameter int X0      = 24,
    parameter int Y0      = 4,
    parameter int CELL    = 14,
    parameter int TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clr_req,
    input  logic       disk_req,
    input  logic [2:0] disk_col,
    input  logic [2:0] disk_row,
    input  logic       disk_side,
    input  logic       cur_req,
    input  logic [2:0] cur_col,
    input  logic [2:0] cur_row,
    output logic       clr_gnt,
    output logic       disk_gnt,
    output logic       cur_gnt,
    output logic       clr_done,
    output logic       disk_done,
    output logic       cur_done,
    output logic [7:0] x_plot,
    output logic [6:0] y_plot,
    output logic [1:0] select,
    output logic       enable,
    input  logic       plot_done,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {JOB_CLR = 2'd0, JOB_DISK = 2'd1, JOB_CUR = 2'd2} job_t;

    state_t     state_q, state_d;
    job_t       job_q, job_d;
    logic [5:0] cell_q, cell_d, cell_nxt;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] done_q, done_d;
    logic [2:0] col_n, row_n;
    logic       load, fire;

`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
    assign fire = plot_done || (wcnt_q == CW'(TIMEOUT - 1));
    assign err  = err_q;
`else
    assign fire = plot_done;
    // Constant zero; TIMEOUT only matters when the watchdog is built in
    assign err  = (TIMEOUT < 0);
`endif

    assign cell_nxt = cell_q + 6'd1;

    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        cell_d  = cell_q;
        sel_d   = sel_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 3'b000;
        col_n   = 3'd0;
        row_n   = 3'd0;
        load    = 1'b0;
`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    job_d  = JOB_CLR;
                    cell_d = 6'd0;
                    sel_d  = 2'b00;
                    load   = 1'b1;
                end else if (disk_req) begin
                    job_d  = JOB_DISK;
                    col_n  = disk_col;
                    row_n  = disk_row;
                    sel_d  = disk_side ? 2'b10 : 2'b01;
                    load   = 1'b1;
                end else if (cur_req) begin
                    job_d  = JOB_CUR;
                    col_n  = cur_col;
                    row_n  = cur_row;
                    sel_d  = 2'b11;
                    load   = 1'b1;
                end
                if (load) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            WAIT: begin
                if (fire) begin
`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
                    if (!plot_done) err_d = 1'b1;
`endif
                    // Clear sweep skips IDLE between cells so it cannot be preempted
                    if (job_q == JOB_CLR && cell_q != 6'd63) begin
                        cell_d  = cell_nxt;
                        col_n   = cell_nxt[2:0];
                        row_n   = cell_nxt[5:3];
                        load    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        done_d  = 3'b001 << job_q;
                        state_d = IDLE;
                    end
                end
`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
                else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            x_d = 8'(X0 + int'(col_n) * CELL);
            y_d = 7'(Y0 + int'(row_n) * CELL);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            job_q   <= JOB_CLR;
            cell_q  <= 6'd0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            sel_q   <= 2'b00;
            done_q  <= 3'b000;
`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
            wcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            cell_q  <= cell_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign enable    = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign clr_gnt   = enable && (job_q == JOB_CLR) && (cell_q == 6'd0);
    assign disk_gnt  = enable && (job_q == JOB_DISK);
    assign cur_gnt   = enable && (job_q == JOB_CUR);
    assign clr_done  = done_q[0];
    assign disk_done = done_q[1];
    assign cur_done  = done_q[2];
    assign x_plot    = x_q;
    assign y_plot    = y_q;
    assign select    = sel_q;
endmodule

// File: tb/tb_othello_draw_arbiter.sv
// tb/tb_othello_draw_arbiter.sv - self-checking bench for othello_draw_arbiter
module tb_othello_draw_arbiter;
    localparam int X0 = 24;
    localparam int Y0 = 4;
    localparam int CELL = 14;
    localparam int TO = 1024;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       clr_req = 1'b0, disk_req = 1'b0, disk_side = 1'b0, cur_req = 1'b0, plot_done = 1'b0;
    logic [2:0] disk_col = 3'd0, disk_row = 3'd0, cur_col = 3'd0, cur_row = 3'd0;
    logic       clr_gnt, disk_gnt, cur_gnt, clr_done, disk_done, cur_done, enable, busy, err;
    logic [7:0] x_plot;
    logic [6:0] y_plot;
    logic [1:0] select;

    othello_draw_arbiter dut (
        .clock(clock), .resetn(resetn),
        .clr_req(clr_req),
        .disk_req(disk_req), .disk_col(disk_col), .disk_row(disk_row), .disk_side(disk_side),
        .cur_req(cur_req), .cur_col(cur_col), .cur_row(cur_row),
        .clr_gnt(clr_gnt), .disk_gnt(disk_gnt), .cur_gnt(cur_gnt),
        .clr_done(clr_done), .disk_done(disk_done), .cur_done(cur_done),
        .x_plot(x_plot), .y_plot(y_plot), .select(select),
        .enable(enable), .plot_done(plot_done), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;
    int pd_mode = 0;
    int ad = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passes++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp_v);
    endtask

    // Reference model: job kind, cell index within job, and phase of the current cell
    int m_phase = 0, m_job = 0, m_cell = 0, m_col = 0, m_row = 0, m_sel = 0;
    int m_done = -1, m_err = 0, m_wcnt = 0;
    bit m_loaded = 1'b0, m_fire = 1'b0;

    initial forever begin
        @(posedge clock or negedge resetn);
        if (!resetn) begin
            m_phase = 0; m_job = 0; m_cell = 0; m_col = 0; m_row = 0; m_sel = 0;
            m_done = -1; m_err = 0; m_wcnt = 0; m_loaded = 1'b0;
        end else begin
            m_done = -1;
            if (m_phase == 0) begin
                if (clr_req) begin
                    m_job = 0; m_cell = 0; m_col = 0; m_row = 0; m_sel = 0;
                end else if (disk_req) begin
                    m_job = 1; m_col = disk_col; m_row = disk_row; m_sel = disk_side ? 2 : 1;
                end else if (cur_req) begin
                    m_job = 2; m_col = cur_col; m_row = cur_row; m_sel = 3;
                end
                if (clr_req || disk_req || cur_req) begin
                    m_phase = 1;
                    m_loaded = 1'b1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_wcnt = 0;
            end else begin
                m_fire = plot_done;
`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
                if (!plot_done && m_wcnt == TO - 1) begin
                    m_fire = 1'b1;
                    m_err = 1;
                end
`endif
                if (m_fire) begin
                    if (m_job == 0 && m_cell < 63) begin
                        m_cell++;
                        m_col = m_cell % 8;
                        m_row = m_cell / 8;
                        m_phase = 1;
                    end else begin
                        m_done = m_job;
                        m_phase = 0;
                    end
                end else begin
                    m_wcnt++;
                end
            end
        end
    end

    function automatic logic [25:0] exp_vec();
        logic [2:0] g, d;
        int ex, ey;
        g = 3'b000;
        d = 3'b000;
        if (m_phase == 1 && (m_job != 0 || m_cell == 0)) g = 3'(1 << m_job);
        if (m_done >= 0) d = 3'(1 << m_done);
        ex = m_loaded ? (X0 + m_col * CELL) % 256 : 0;
        ey = m_loaded ? (Y0 + m_row * CELL) % 128 : 0;
        return {g, d, ex[7:0], ey[6:0], m_sel[1:0], m_phase == 1, m_phase != 0, m_err[0]};
    endfunction

    function automatic logic [25:0] act_vec();
        return {cur_gnt, disk_gnt, clr_gnt, cur_done, disk_done, clr_done,
                x_plot, y_plot, select, enable, busy, err};
    endfunction

    initial forever begin
        @(negedge clock);
        if (cmp_en) chk("outputs_vs_model", int'(act_vec()), int'(exp_vec()));
    end

    function automatic logic sig(input int s);
        case (s)
            0: return clr_gnt;
            1: return disk_gnt;
            2: return cur_gnt;
            3: return clr_done;
            4: return disk_done;
            default: return cur_done;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #2;
        if (pd_mode == 1) begin
            if (enable) begin
                ad = $urandom_range(1, 3);
                plot_done = 1'b0;
            end else if (ad > 0) begin
                ad--;
                plot_done = (ad == 0);
            end else begin
                plot_done = 1'b0;
            end
        end else if (pd_mode == 2) begin
            plot_done = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic wait_for(input int s, input int budget, input string nm, output int n);
        n = 0;
        while (!sig(s) && n < budget) begin
            step();
            n++;
        end
        chk(nm, int'(sig(s)), 1);
    endtask

    initial begin
        int n, en_cnt, clr_en, clrd;
        int ev[$];
        resetn = 1'b0;
        repeat (3) step();
        chk("reset_outputs", int'(act_vec()), 0);
        cmp_en = 1'b1;
        resetn = 1'b1;
        step();

        // Cursor at col 2 row 3
        cur_col = 3'd2; cur_row = 3'd3; cur_req = 1'b1;
        wait_for(2, 10, "cur_gnt", n);
        chk("cur_enable", int'(enable), 1);
        chk("cur_x", int'(x_plot), 52);
        chk("cur_y", int'(y_plot), 46);
        chk("cur_sel", int'(select), 3);
        cur_req = 1'b0;
        repeat (4) step();
        chk("cur_busy_wait", int'(busy), 1);
        plot_done = 1'b1; step(); plot_done = 1'b0;
        chk("cur_done", int'(cur_done), 1);
        chk("cur_busy_after", int'(busy), 0);

        // White disk at far corner, inputs scrambled after grant
        step();
        disk_side = 1'b1; disk_col = 3'd7; disk_row = 3'd7; disk_req = 1'b1;
        wait_for(1, 10, "disk_gnt", n);
        chk("disk_x", int'(x_plot), 122);
        chk("disk_y", int'(y_plot), 102);
        chk("disk_sel", int'(select), 2);
        disk_req = 1'b0; disk_col = 3'd0; disk_row = 3'd0; disk_side = 1'b0;
        step(); step();
        chk("disk_x_hold", int'(x_plot), 122);
        chk("disk_y_hold", int'(y_plot), 102);
        chk("disk_sel_hold", int'(select), 2);
        plot_done = 1'b1; step(); plot_done = 1'b0;
        chk("disk_done", int'(disk_done), 1);

        // plot_done in IDLE and in ISSUE must be ignored
        repeat (2) step();
        plot_done = 1'b1; step(); plot_done = 1'b0;
        chk("idle_pd_nodone", int'({clr_done, disk_done, cur_done}), 0);
        chk("idle_pd_busy", int'(busy), 0);
        cur_col = 3'd1; cur_row = 3'd1; cur_req = 1'b1;
        wait_for(2, 10, "issue_pd_gnt", n);
        plot_done = 1'b1; step(); plot_done = 1'b0; cur_req = 1'b0;
        chk("issue_pd_busy", int'(busy), 1);
        step();
        chk("issue_pd_nodone", int'({clr_done, disk_done, cur_done}), 0);
        plot_done = 1'b1; step(); plot_done = 1'b0;
        chk("issue_pd_done", int'(cur_done), 1);

        // Simultaneous requests: clear sweep first, then disk, then cursor
        step();
        pd_mode = 1; ad = 0;
        clr_req = 1'b1; disk_req = 1'b1; disk_col = 3'd3; disk_row = 3'd5; disk_side = 1'b0;
        cur_req = 1'b1; cur_col = 3'd6; cur_row = 3'd0;
        en_cnt = 0; clr_en = -1; n = 0;
        ev.delete();
        while (n < 1500 && !cur_done) begin
            step();
            n++;
            if (enable) en_cnt++;
            if (clr_gnt) begin ev.push_back(0); clr_req = 1'b0; end
            if (disk_gnt) begin ev.push_back(1); disk_req = 1'b0; end
            if (cur_gnt) begin ev.push_back(2); cur_req = 1'b0; end
            if (clr_done) begin ev.push_back(10); clr_en = en_cnt; end
        end
        pd_mode = 0; plot_done = 1'b0;
        chk("prio_finished", int'(cur_done), 1);
        chk("prio_events", ev.size(), 4);
        chk("prio_ev0_clr_gnt", ev.size() > 0 ? ev[0] : -1, 0);
        chk("prio_ev1_clr_done", ev.size() > 1 ? ev[1] : -1, 10);
        chk("prio_ev2_disk_gnt", ev.size() > 2 ? ev[2] : -1, 1);
        chk("prio_ev3_cur_gnt", ev.size() > 3 ? ev[3] : -1, 2);
        chk("clr_enables", clr_en, 64);
        chk("total_enables", en_cnt, 66);

        // Reset while clearing cell 30, then restart from cell 0
        step();
        pd_mode = 1; ad = 0; clr_req = 1'b1;
        en_cnt = 0; clrd = 0; n = 0;
        while (n < 600 && en_cnt < 31) begin
            step();
            n++;
            if (enable) en_cnt++;
            if (clr_done) clrd++;
        end
        chk("cell30_reached", en_cnt, 31);
        chk("cell30_x", int'(x_plot), 108);
        chk("cell30_y", int'(y_plot), 46);
        pd_mode = 0; plot_done = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        chk("reset_async", int'(act_vec()), 0);
        step(); step();
        resetn = 1'b1;
        chk("no_clr_done_before_reset", clrd, 0);
        pd_mode = 1; ad = 0;
        wait_for(0, 10, "clr_regrant", n);
        chk("restart_x", int'(x_plot), 24);
        chk("restart_y", int'(y_plot), 4);
        clr_req = 1'b0;
        wait_for(3, 600, "clr_done_after_restart", n);
        pd_mode = 0; plot_done = 1'b0;

        // plothelper never answers
        step();
        cur_col = 3'd0; cur_row = 3'd0; cur_req = 1'b1;
        wait_for(2, 10, "to_gnt", n);
        cur_req = 1'b0;
`ifdef OTHELLO_DRAW_ARB_TIMEOUT_EN
        wait_for(5, 1100, "to_done", n);
        chk("to_latency", n, TO + 1);
        chk("to_err", int'(err), 1);
        repeat (3) step();
        chk("to_err_sticky", int'(err), 1);
`else
        repeat (1100) step();
        chk("hold_busy", int'(busy), 1);
        chk("hold_err", int'(err), 0);
`endif
        resetn = 1'b0; step(); resetn = 1'b1; step();

        // Randomized traffic against the model
        pd_mode = 2;
        repeat (3000) begin
            clr_req   = ($urandom_range(0, 99) < 2);
            disk_req  = ($urandom_range(0, 3) == 0);
            disk_col  = 3'($urandom);
            disk_row  = 3'($urandom);
            disk_side = 1'($urandom);
            cur_req   = ($urandom_range(0, 3) == 0);
            cur_col   = 3'($urandom);
            cur_row   = 3'($urandom);
            resetn    = ($urandom_range(0, 999) != 0);
            step();
        end
        pd_mode = 0; plot_done = 1'b0;
        clr_req = 1'b0; disk_req = 1'b0; cur_req = 1'b0; resetn = 1'b1;
        repeat (5) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/othello_draw_arbiter.md
OTHELLO_DRAW_ARBITER -- requirements
Module: othello_draw_arbiter

Interface
REQ-001 Parameters, one per line: X0, 24, board left pixel; Y0, 4, board top pixel; CELL, 14, cell pitch in pixels; TIMEOUT, 1024, watchdog limit in cycles.
REQ-002 Ports, one per line: name  direction  width  meaning.
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 clr_req  in  1  requester 0: repaint all 64 cells empty.
REQ-006 disk_req, disk_col, disk_row, disk_side  in  1/3/3/1  requester 1: paint disk at cell; side 0 black, 1 white.
REQ-007 cur_req, cur_col, cur_row  in  1/3/3  requester 2: paint cursor box at cell.
REQ-008 clr_gnt, disk_gnt, cur_gnt  out  1 each  one-cycle grant pulses.
REQ-009 clr_done, disk_done, cur_done  out  1 each  one-cycle completion pulses.
REQ-010 x_plot, y_plot, select  out  8/7/2  cell origin and paint type to plothelper.
REQ-011 enable  out  1  one-cycle start pulse to plothelper.
REQ-012 plot_done  in  1  one-cycle pulse from plothelper when a cell finishes.
REQ-013 busy, err  out  1 each  job in progress; sticky watchdog error.

Function
REQ-014 States IDLE, ISSUE, WAIT only; IDLE to ISSUE when any request sampled high; ISSUE to WAIT unconditionally; WAIT exits on plot_done.
REQ-015 Fixed priority when simultaneous: clr_req > disk_req > cur_req; losers stay pending, never dropped while held.
REQ-016 Grant pulses in the ISSUE cycle of the job's first cell; col/row/side latched at the IDLE sampling edge; later input changes ignored.
REQ-017 Requester must hold req until its gnt; req dropped before gnt is a withdrawal, no grant or done.
REQ-018 x_plot = X0 + col*CELL, y_plot = Y0 + row*CELL, computed at full width then truncated to 8/7 bits; defaults never overflow (max 122/102).
REQ-019 select encoding: 00 empty, 01 black disk, 10 white disk, 11 cursor box.
REQ-020 enable high exactly one cycle, in ISSUE; x_plot/y_plot/select stable from ISSUE until leaving WAIT.
REQ-021 plot_done ignored outside WAIT.
REQ-022 Disk/cursor job: one cell; done pulses the cycle after plot_done sampled, state returns to IDLE.
REQ-023 Clear job: 64 cells, row-major row 0 col 0 to row 7 col 7, select 00; after each non-final plot_done go directly to ISSUE of next cell; clr_done after 64th plot_done only.
REQ-024 No preemption: pending requests wait for current job, including full clear sweep.
REQ-025 Minimum one IDLE cycle between jobs; back-to-back grants spaced at least 3 cycles.
REQ-026 busy high in ISSUE and WAIT, low in IDLE.

Reset
REQ-027 resetn low: state IDLE, all gnt/done/enable/busy/err 0, x_plot/y_plot/select 0, sweep counter 0, immediately and asynchronously.
REQ-028 Reset mid-job aborts it; no done issued; requests re-arbitrated from IDLE after release.

Configuration
REQ-029 Macro OTHELLO_DRAW_ARB_TIMEOUT_EN defined: WAIT counter counts cycles; reaching TIMEOUT without plot_done behaves as plot_done and sets err until reset.
REQ-030 Macro undefined: no counter, WAIT held indefinitely, err tied 0.

Verification
REQ-031 cur_req=1, col=2,row=3 -> cur_gnt and enable in same cycle, x_plot=52, y_plot=46, select=11; plot_done 5 cycles later -> cur_done next cycle, busy 0.
REQ-032 clr_req, disk_req, cur_req raised same edge -> clr_gnt first, 64 enable pulses, clr_done, then disk_gnt, then cur_gnt.
REQ-033 disk_req side=1 col=7 row=7 -> x_plot=122, y_plot=102, select=10; inputs changed after grant do not alter outputs.
REQ-034 resetn low during clear cell 30 -> all outputs 0 at once, no clr_done; clr_req still high after release -> sweep restarts at cell 0.
REQ-035 Macro defined, plot_done never returned -> done pulse after 1024 WAIT cycles, err=1 sticky; macro undefined -> busy stays 1, err 0.
REQ-036 plot_done pulsed during ISSUE and IDLE -> ignored, no spurious done.
